// File: rtl/ataque_tabuleiro.sv
// ----------------------------------------------------------------------------
// ataque_tabuleiro
// Attack stage of the battleship game. Once the positioning stage raises
// game_en, the frozen ship map is scanned one cell per cycle to count ship
// cells. The block then accepts shots from row/column switches and a fire
// button, records hits and misses in separate maps, and counts down the
// remaining shots until the game is won or lost.
//
// Optional feature (compile-time macro DEBOUNCE_EN):
//   defined   -> the synchronised fire level must hold for DEBOUNCE_CYCLES
//                consecutive cycles before it is accepted, so short glitches
//                never fire a shot.
//   undefined -> no filter; DEBOUNCE_CYCLES is not declared.
//
// Ports
//   clk_div     game clock (single domain)
//   rst_n       asynchronous active-low reset
//   game_en     1 = attack phase active; 0 returns to IDLE and clears state
//   pos_map     ship map, bit r*COLS+c = row r / column c (stable while game_en=1)
//   row_sel     shot row
//   col_sel     shot column
//   fire        raw fire button, active-high, asynchronous
//   hit_map     cells shot and hit
//   miss_map    cells shot and missed
//   shots_left  remaining shots
//   hits_cnt    hits so far
//   ship_total  ship cells counted during the scan
//   hit_p       one-cycle pulse: last shot hit
//   miss_p      one-cycle pulse: last shot missed
//   err_p       one-cycle pulse: shot rejected (bad coordinate or repeat)
//   busy        high while scanning or evaluating a shot
//   win / lose  end-of-game levels
// ----------------------------------------------------------------------------
module ataque_tabuleiro #(
  parameter int ROWS      = 7,
  parameter int COLS      = 5,
  parameter int MAX_SHOTS = 20
`ifdef DEBOUNCE_EN
  , parameter int DEBOUNCE_CYCLES = 16
`endif
) (
  input  logic                                clk_div,
  input  logic                                rst_n,
  input  logic                                game_en,
  input  logic [ROWS*COLS-1:0]                pos_map,
  input  logic [2:0]                          row_sel,
  input  logic [2:0]                          col_sel,
  input  logic                                fire,
  output logic [ROWS*COLS-1:0]                hit_map,
  output logic [ROWS*COLS-1:0]                miss_map,
  output logic [$clog2(MAX_SHOTS+1)-1:0]      shots_left,
  output logic [$clog2(ROWS*COLS+1)-1:0]      hits_cnt,
  output logic [$clog2(ROWS*COLS+1)-1:0]      ship_total,
  output logic                                hit_p,
  output logic                                miss_p,
  output logic                                err_p,
  output logic                                busy,
  output logic                                win,
  output logic                                lose
);

  localparam int CELLS  = ROWS * COLS;
  localparam int IDX_W  = $clog2(CELLS);
  localparam int CNT_W  = $clog2(CELLS + 1);
  localparam int SHOT_W = $clog2(MAX_SHOTS + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SCAN      = 3'd1,
    S_WAIT_SHOT = 3'd2,
    S_EVAL      = 3'd3,
    S_WIN       = 3'd4,
    S_LOSE      = 3'd5
  } state_t;

  // ---------------------------------------------------------------- fire path
  logic fire_s1_q, fire_s2_q, fire_s3_q;
  logic fire_level_s;
  logic fire_edge_s;

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      fire_s1_q <= 1'b0;
      fire_s2_q <= 1'b0;
    end else begin
      fire_s1_q <= fire;
      fire_s2_q <= fire_s1_q;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic            db_level_q;
  logic [DB_W-1:0] db_cnt_q;

  // Filtered level follows the synchronised level only after it has
  // disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      db_level_q <= 1'b0;
      db_cnt_q   <= '0;
    end else if (fire_s2_q == db_level_q) begin
      db_cnt_q   <= '0;
    end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      db_level_q <= fire_s2_q;
      db_cnt_q   <= '0;
    end else begin
      db_cnt_q   <= db_cnt_q + DB_W'(1);
    end
  end

  assign fire_level_s = db_level_q;
`else
  assign fire_level_s = fire_s2_q;
`endif

  // Delayed copy of the (filtered) level for rising-edge detection.
  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      fire_s3_q <= 1'b0;
    end else begin
      fire_s3_q <= fire_level_s;
    end
  end

  assign fire_edge_s = fire_level_s & ~fire_s3_q;

  // ---------------------------------------------------------------- game FSM
  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CELLS-1:0]   hit_map_q, hit_map_d;
  logic [CELLS-1:0]   miss_map_q, miss_map_d;
  logic [SHOT_W-1:0]  shots_left_q, shots_left_d;
  logic [CNT_W-1:0]   hits_cnt_q, hits_cnt_d;
  logic [CNT_W-1:0]   ship_total_q, ship_total_d;
  logic               hit_p_q, hit_p_d;
  logic               miss_p_q, miss_p_d;
  logic               err_p_q, err_p_d;
  logic               busy_q, busy_d;
  logic               win_q, win_d;
  logic               lose_q, lose_d;

  logic [IDX_W-1:0]   shot_idx_s;
  logic               coord_bad_s;
  logic               already_s;

  // Shot cell index; only meaningful when the coordinate is in range.
  assign shot_idx_s  = IDX_W'(row_sel) * IDX_W'(COLS) + IDX_W'(col_sel);
  assign coord_bad_s = (int'(row_sel) >= ROWS) || (int'(col_sel) >= COLS);
  assign already_s   = hit_map_q[shot_idx_s] | miss_map_q[shot_idx_s];

  // State register and all registered outputs.
  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      hit_map_q    <= '0;
      miss_map_q   <= '0;
      shots_left_q <= SHOT_W'(MAX_SHOTS);
      hits_cnt_q   <= '0;
      ship_total_q <= '0;
      hit_p_q      <= 1'b0;
      miss_p_q     <= 1'b0;
      err_p_q      <= 1'b0;
      busy_q       <= 1'b0;
      win_q        <= 1'b0;
      lose_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      hit_map_q    <= hit_map_d;
      miss_map_q   <= miss_map_d;
      shots_left_q <= shots_left_d;
      hits_cnt_q   <= hits_cnt_d;
      ship_total_q <= ship_total_d;
      hit_p_q      <= hit_p_d;
      miss_p_q     <= miss_p_d;
      err_p_q      <= err_p_d;
      busy_q       <= busy_d;
      win_q        <= win_d;
      lose_q       <= lose_d;
    end
  end

  // Next-state, datapath updates and pulse generation.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    hit_map_d    = hit_map_q;
    miss_map_d   = miss_map_q;
    shots_left_d = shots_left_q;
    hits_cnt_d   = hits_cnt_q;
    ship_total_d = ship_total_q;
    hit_p_d      = 1'b0;
    miss_p_d     = 1'b0;
    err_p_d      = 1'b0;

    if (!game_en) begin
      // Dropping game_en abandons whatever game was in progress.
      state_d      = S_IDLE;
      idx_d        = '0;
      hit_map_d    = '0;
      miss_map_d   = '0;
      shots_left_d = SHOT_W'(MAX_SHOTS);
      hits_cnt_d   = '0;
      ship_total_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d      = S_SCAN;
          idx_d        = '0;
          ship_total_d = '0;
        end
        S_SCAN: begin
          ship_total_d = ship_total_q + CNT_W'(pos_map[idx_q]);
          if (idx_q == IDX_W'(CELLS - 1)) begin
            // An empty board is won without firing.
            if (ship_total_d == CNT_W'(0)) begin
              state_d = S_WIN;
            end else begin
              state_d = S_WAIT_SHOT;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        S_WAIT_SHOT: begin
          if (fire_edge_s) begin
            // Rejected shots do not consume a shot.
            if (coord_bad_s) begin
              err_p_d = 1'b1;
            end else if (already_s) begin
              err_p_d = 1'b1;
            end else begin
              idx_d   = shot_idx_s;
              state_d = S_EVAL;
            end
          end else begin
            state_d = S_WAIT_SHOT;
          end
        end
        S_EVAL: begin
          shots_left_d = shots_left_q - SHOT_W'(1);
          if (pos_map[idx_q]) begin
            hit_map_d[idx_q] = 1'b1;
            hits_cnt_d       = hits_cnt_q + CNT_W'(1);
            hit_p_d          = 1'b1;
          end else begin
            miss_map_d[idx_q] = 1'b1;
            miss_p_d          = 1'b1;
          end
          // Sinking the last ship on the final shot counts as a win.
          if (hits_cnt_d == ship_total_q) begin
            state_d = S_WIN;
          end else if (shots_left_d == SHOT_W'(0)) begin
            state_d = S_LOSE;
          end else begin
            state_d = S_WAIT_SHOT;
          end
        end
        S_WIN:   state_d = S_WIN;
        S_LOSE:  state_d = S_LOSE;
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d == S_SCAN) || (state_d == S_EVAL);
    win_d  = (state_d == S_WIN);
    lose_d = (state_d == S_LOSE);
  end

  assign hit_map    = hit_map_q;
  assign miss_map   = miss_map_q;
  assign shots_left = shots_left_q;
  assign hits_cnt   = hits_cnt_q;
  assign ship_total = ship_total_q;
  assign hit_p      = hit_p_q;
  assign miss_p     = miss_p_q;
  assign err_p      = err_p_q;
  assign busy       = busy_q;
  assign win        = win_q;
  assign lose       = lose_q;

endmodule
